// File: rtl/mult16x9_seq.sv
// -----------------------------------------------------------------------------
// mult16x9_seq -- sequential radix-2 shift-add unsigned multiplier
//
// Purpose:
//   Accepts one unsigned operand pair (a, b) per transaction and runs BW
//   shift-add iterations. It then presents the registered AW+BW-bit product.
//   The partial-product accumulator is a structural ripple-carry adder built
//   from AW fulladder cells. Latency is fixed: the output becomes valid BW
//   cycles after the input handshake, and zero operands take no shortcut.
//
// Ports (mult16x9_seq):
//   clk        in   1      rising-edge clock, sole clock domain
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   AW     unsigned multiplicand, sampled at input handshake
//   b          in   BW     unsigned multiplier, sampled at input handshake
//   out_valid  out  1      product valid (DONE only)
//   out_ready  in   1      downstream accepts product
//   product    out  AW+BW  unsigned a*b, registered
//
// Ports (fulladder):
//   a, b, cin  in   1      addend bits and carry in
//   sum, cout  out  1      sum bit and carry out
// -----------------------------------------------------------------------------

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module mult16x9_seq #(
    parameter int AW = 16,
    parameter int BW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     a,
    input  logic [BW-1:0]     b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW+BW-1:0]  product
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [AW-1:0]       mcand_r;
    // The high half of the accumulator is nominally AW+1 bits wide. Its MSB is
    // always zero right after the shift, so only the AW live bits are stored.
    // The carry out of the adder reaches the register through sum_s[AW],
    // which is shifted down into acc_hi_r[AW-1].
    logic [AW-1:0]       acc_hi_r;
    logic [BW-1:0]       acc_lo_r;
    logic [CW-1:0]       count_r;
    logic [AW+BW-1:0]    product_r;
    logic                in_ready_r;
    logic                out_valid_r;

    logic [AW-1:0]       addend_s;
    logic [AW:0]         carry_s;
    logic [AW:0]         sum_s;

    // Select the multiplicand or zero, depending on the current multiplier LSB.
    always_comb begin
        addend_s = '0;
        if (acc_lo_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = '0;
        end
    end

    // Ripple-carry chain: bit 0 has no carry in, and the last carry is sum MSB.
    assign carry_s[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_fa
            fulladder u_fa (
                .a    (acc_hi_r[gi]),
                .b    (addend_s[gi]),
                .cin  (carry_s[gi]),
                .sum  (sum_s[gi]),
                .cout (carry_s[gi+1])
            );
        end
    endgenerate

    assign sum_s[AW] = carry_s[AW];

    // Control FSM and datapath registers. Handshake outputs are registered
    // alongside the state, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mcand_r     <= '0;
            acc_hi_r    <= '0;
            acc_lo_r    <= '0;
            count_r     <= '0;
            product_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_r    <= a;
                        acc_hi_r   <= '0;
                        acc_lo_r   <= b;
                        count_r    <= '0;
                        state_r    <= ST_BUSY;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Shift {sum, acc_lo} right by one. The sum's MSB enters
                    // the high half, and the consumed multiplier LSB drops out.
                    acc_hi_r <= sum_s[AW:1];
                    acc_lo_r <= {sum_s[0], acc_lo_r[BW-1:1]};
                    if (count_r == CNT_LAST) begin
                        product_r   <= {sum_s, acc_lo_r[BW-1:1]};
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // No new accept on the same edge. IDLE is revisited first.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;

endmodule

// File: tb/tb_mult16x9_seq.sv
// -----------------------------------------------------------------------------
// tb_mult16x9_seq -- scoreboard bench for mult16x9_seq
//
// An input monitor pushes the arithmetic product a*b and the accept edge into
// a queue at every input handshake. An output monitor compares each presented
// product against the queue head, checks the fixed latency, and pops on the
// output handshake. Directed cases come first, then 1000 random operand pairs
// with random gaps and random downstream backpressure.
// -----------------------------------------------------------------------------

module tb_mult16x9_seq;

    localparam int AW  = 16;
    localparam int BW  = 9;
    localparam int LAT = BW;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     a;
    logic [BW-1:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [AW+BW-1:0]  product;

    typedef struct {
        logic [AW+BW-1:0] prod;
        int               acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic ov_prev = 1'b0;
    logic rand_or = 1'b0;

    mult16x9_seq #(.AW(AW), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Input monitor: the reference product is plain multiplication.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            e.prod    = {{BW{1'b0}}, a} * {{AW{1'b0}}, b};
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
    end

    // Output monitor: check latency on the rising edge of valid, and stability
    // while held. Pop on the output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got 0x%0h expected no output", product);
            end else begin
                if (!ov_prev) begin
                    chk("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(LAT));
                end
                chk("product", 32'(product), 32'(sb_q[0].prod));
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    void'(sb_q.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    end

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_or) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [AW-1:0] av, input logic [BW-1:0] bv);
        int k;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        k        = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 9'($urandom);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || out_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0 || out_valid) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end else begin
            chk("in_ready_after_out", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] av;
        logic [BW-1:0] bv;
        int            k;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic transaction, maximum operands, and no early-out for zero.
        send(16'h0003, 9'h005);
        wait_drain();
        send(16'hFFFF, 9'h1FF);
        wait_drain();
        send(16'h1234, 9'h100);
        wait_drain();
        send(16'h0000, 9'h1AB);
        wait_drain();

        // Backpressure: the product must hold, and new operands must be ignored.
        out_ready = 1'b0;
        send(16'hABCD, 9'h003);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            a        = 16'($urandom);
            b        = 9'($urandom);
            @(negedge clk);
            chk("bp_valid_held", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset during the 4th busy cycle aborts the in-flight operation.
        send(16'h00FF, 9'h0FF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h0002, 9'h003);
        wait_drain();

        // Random operand pairs with gaps and random backpressure.
        rand_or = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 7))
                0:       av = 16'h0000;
                1:       av = 16'hFFFF;
                default: av = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       bv = 9'h000;
                1:       bv = 9'h1FF;
                default: bv = 9'($urandom);
            endcase
            send(av, bv);
        end
        rand_or = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
